// File: rtl/mem_loader_pkg.sv
// Shared types for the memory loader: FSM state encoding, byte-lane index and
// byte insert/extract helpers used by both the packer and the top.
package mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTES_PER_WORD * 8;

    typedef logic [$clog2(BYTES_PER_WORD)-1:0] lane_t;

    localparam lane_t LAST_LANE = lane_t'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WRITE     = 3'd2,
        ST_DONE      = 3'd3,
        ST_DUMP_RD   = 3'd4,
        ST_DUMP_WAIT = 3'd5,
        ST_DUMP_TX   = 3'd6
    } state_t;

    // Little-endian lanes: lane 0 occupies bits 7:0.
    function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] word,
                                                   input lane_t             lane,
                                                   input logic [7:0]        data);
        logic [WORD_W-1:0] w_tmp;
        w_tmp = word;
        w_tmp[int'(lane)*8 +: 8] = data;
        return w_tmp;
    endfunction

    function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] word,
                                            input lane_t             lane);
        return word[int'(lane)*8 +: 8];
    endfunction

endpackage

// File: rtl/mem_loader_packer.sv
// Byte-lane pack/unpack register with lane counter. Loads assemble a word one
// byte at a time; dumps load a whole word and step the lane counter outward.
module mem_loader_packer
    import mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [7:0]        i_byte,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_advance,
    output logic [WORD_W-1:0] o_word,
    output lane_t             o_lane,
    output logic              o_last
);

    logic [WORD_W-1:0] r_word;
    lane_t             r_lane;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_lane <= '0;
        end else if (i_push) begin
            r_word <= put_byte(r_word, r_lane, i_byte);
            r_lane <= r_lane + lane_t'(1);
        end else if (i_advance) begin
            r_lane <= r_lane + lane_t'(1);
        end
    end

    assign o_word = r_word;
    assign o_lane = r_lane;
    assign o_last = (r_lane == LAST_LANE);

endmodule

// File: rtl/mem_loader.sv
// Loads program memory from a byte stream while holding the core in reset.
// Optional read-back (dump) path is built only when MEM_LOADER_DUMP_EN is defined.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int N      = 32,
    parameter int LENGTH = 1024,
    parameter int AW     = $clog2(LENGTH)
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load_start,
    input  logic [AW:0]  load_count,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic         wr_ena1,
    output logic [N-1:0] addr1,
    output logic [N-1:0] din1,
    input  logic [N-1:0] dout1,
    output logic         core_rst,
    output logic         busy,
    output logic         done
`ifdef MEM_LOADER_DUMP_EN
    ,
    input  logic         dump_start,
    input  logic [AW:0]  dump_count,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data
`endif
);

    localparam logic [AW:0] LEN_C = (AW+1)'(LENGTH);

    function automatic logic [AW:0] clamp_count(input logic [AW:0] cnt);
        return (cnt > LEN_C) ? LEN_C : cnt;
    endfunction

    state_t            r_state;
    logic [AW:0]       r_count;
    logic [AW:0]       r_index;

    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_next_word;
    lane_t             w_lane;
    logic              w_last_lane;
    logic              w_idle;
    logic              w_start_load;
    logic              w_start_dump;
    logic              w_push;
    logic              w_load;
    logic              w_advance;
    logic [AW:0]       w_load_cnt;
    logic [AW:0]       w_index_next;
    logic              w_last_word;

    assign w_idle       = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start_load = w_idle && load_start;
    assign w_push       = (r_state == ST_LOAD) && in_valid && in_ready;
    assign w_load_cnt   = clamp_count(load_count);
    assign w_index_next = r_index + (AW+1)'(1);
    assign w_last_word  = (w_index_next == r_count);
    assign w_next_word  = put_byte(w_word, w_lane, in_data);

`ifdef MEM_LOADER_DUMP_EN
    logic [AW:0] w_dump_cnt;
    assign w_dump_cnt   = clamp_count(dump_count);
    // Load has priority when both start pulses coincide.
    assign w_start_dump = w_idle && dump_start && !load_start;
    assign w_load       = (r_state == ST_DUMP_WAIT);
    assign w_advance    = (r_state == ST_DUMP_TX) && out_ready && !w_last_lane;
`else
    assign w_start_dump = 1'b0;
    assign w_load       = 1'b0;
    assign w_advance    = 1'b0;
`endif

    mem_loader_packer u_packer (
        .clk       (clk),
        .rstb      (rstb),
        .i_clr     (w_start_load | w_start_dump),
        .i_push    (w_push),
        .i_byte    (in_data),
        .i_load    (w_load),
        .i_word    (WORD_W'(dout1)),
        .i_advance (w_advance),
        .o_word    (w_word),
        .o_lane    (w_lane),
        .o_last    (w_last_lane)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_index  <= '0;
            in_ready <= 1'b0;
            wr_ena1  <= 1'b0;
            addr1    <= '0;
            din1     <= '0;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef MEM_LOADER_DUMP_EN
            out_valid <= 1'b0;
            out_data  <= '0;
`endif
        end else begin
            wr_ena1 <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_load) begin
                        r_count <= w_load_cnt;
                        r_index <= '0;
                        if (w_load_cnt == '0) begin
                            r_state  <= ST_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            core_rst <= 1'b0;
                        end else begin
                            r_state  <= ST_LOAD;
                            in_ready <= 1'b1;
                            core_rst <= 1'b1;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
`ifdef MEM_LOADER_DUMP_EN
                    // Dump leaves core_rst alone: reading memory back never disturbs the core.
                    else if (w_start_dump) begin
                        r_count <= w_dump_cnt;
                        r_index <= '0;
                        if (w_dump_cnt == '0) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= ST_DUMP_RD;
                            addr1   <= '0;
                            done    <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
`endif
                end
                ST_LOAD: begin
                    if (w_push && w_last_lane) begin
                        r_state  <= ST_WRITE;
                        in_ready <= 1'b0;
                        wr_ena1  <= 1'b1;
                        addr1    <= N'(r_index);
                        din1     <= N'(w_next_word);
                    end
                end
                ST_WRITE: begin
                    r_index <= w_index_next;
                    if (w_last_word) begin
                        r_state  <= ST_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        core_rst <= 1'b0;
                    end else begin
                        r_state  <= ST_LOAD;
                        in_ready <= 1'b1;
                    end
                end
`ifdef MEM_LOADER_DUMP_EN
                ST_DUMP_RD: begin
                    r_state <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    r_state   <= ST_DUMP_TX;
                    out_valid <= 1'b1;
                    out_data  <= dout1[7:0];
                end
                ST_DUMP_TX: begin
                    if (out_ready) begin
                        if (w_last_lane) begin
                            out_valid <= 1'b0;
                            r_index   <= w_index_next;
                            if (w_last_word) begin
                                r_state <= ST_DONE;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= ST_DUMP_RD;
                                addr1   <= N'(w_index_next);
                            end
                        end else begin
                            out_data <= get_byte(w_word, w_lane + lane_t'(1));
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of load scenarios with random bytes
// compared against a word-assembly model, plus reset, busy and dump sequences.
`timescale 1ns/1ps
module tb_mem_loader;

    localparam int N      = 32;
    localparam int LENGTH = 1024;
    localparam int AW     = 10;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         load_start = 1'b0;
    logic [AW:0]  load_count = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         wr_ena1;
    logic [N-1:0] addr1;
    logic [N-1:0] din1;
    logic [N-1:0] dout1;
    logic         core_rst;
    logic         busy;
    logic         done;
`ifdef MEM_LOADER_DUMP_EN
    logic         dump_start = 1'b0;
    logic [AW:0]  dump_count = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
`endif

    always #5 clk = ~clk;

    mem_loader #(.N(N), .LENGTH(LENGTH)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .load_start (load_start),
        .load_count (load_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wr_ena1    (wr_ena1),
        .addr1      (addr1),
        .din1       (din1),
        .dout1      (dout1),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done)
`ifdef MEM_LOADER_DUMP_EN
        ,
        .dump_start (dump_start),
        .dump_count (dump_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`endif
    );

    // Memory model: captures writes and serves reads one half-cycle after addr1 settles.
    logic [31:0] mem_model [0:LENGTH-1];
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [7:0]  byteq [$];
    int          bptr = 0;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (wr_ena1) begin
            wq_addr.push_back(addr1);
            wq_data.push_back(din1);
            mem_model[addr1[AW-1:0]] <= din1;
        end
        dout1 <= mem_model[addr1[AW-1:0]];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int cnt;
        int mode;
        int exp_writes;
        int exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        return {byteq[4*i+3], byteq[4*i+2], byteq[4*i+1], byteq[4*i]};
    endfunction

    task automatic fill_random(input int nw);
        byteq.delete();
        for (int i = 0; i < 4*nw; i++) byteq.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic start_op(input bit ld, input int lcnt, input bit dp, input int dcnt);
        @(negedge clk);
        load_start = ld;
        load_count = (AW+1)'(lcnt);
`ifdef MEM_LOADER_DUMP_EN
        dump_start = dp;
        dump_count = (AW+1)'(dcnt);
`endif
        @(negedge clk);
        load_start = 1'b0;
`ifdef MEM_LOADER_DUMP_EN
        dump_start = 1'b0;
`endif
        if (ld) bptr = 0;
    endtask

    task automatic feed(input int nb, input int mode, output int sent);
        int cyc;
        bit pend;
        sent = 0;
        cyc  = 0;
        pend = 1'b0;
        while (sent < nb && cyc < 8*nb + 20) begin
            @(negedge clk);
            cyc++;
            if (pend) sent++;
            if (sent < nb) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = cyc[0];
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                in_data = byteq[bptr + sent];
                pend    = in_valid && in_ready;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        bptr += sent;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " core_rst"}, core_rst, 1);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " wr_ena1"},  wr_ena1,  0);
        chk({tag, " addr1"},    addr1,    0);
        chk({tag, " din1"},     din1,     0);
        chk({tag, " busy"},     busy,     0);
        chk({tag, " done"},     done,     0);
`ifdef MEM_LOADER_DUMP_EN
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_data"},  out_data,  0);
`endif
    endtask

    task automatic run_load(input int cnt, input int mode, input int exp_writes,
                            input int exp_last, input string tag);
        int nw;
        int sent;
        nw = (cnt > LENGTH) ? LENGTH : cnt;
        wq_addr.delete();
        wq_data.delete();
        start_op(1'b1, cnt, 1'b0, 0);
        if (cnt == 0) begin
            chk({tag, " done_next_cycle"}, done, 1);
        end else begin
            chk({tag, " busy_start"}, busy, 1);
            chk({tag, " core_rst_held"}, core_rst, 1);
            chk({tag, " done_cleared"}, done, 0);
        end
        feed(4*nw, mode, sent);
        chk({tag, " bytes_accepted"}, sent, 4*nw);
        wait_done(20);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " core_rst_released"}, core_rst, 0);
        chk({tag, " nwrites"}, wq_addr.size(), exp_writes);
        for (int i = 0; i < wq_addr.size() && i < nw; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), wq_addr[i], i);
            chk($sformatf("%s data[%0d]", tag, i), wq_data[i], model_word(i));
        end
        if (exp_writes > 0 && wq_addr.size() > 0)
            chk({tag, " last_addr"}, wq_addr[wq_addr.size()-1], exp_last);
    endtask

    vec_t vecs[6];
    logic [7:0] fixed_bytes[8];

    initial begin
        int sent;
        int nbefore;

        vecs[0] = '{cnt: 2,    mode: 2, exp_writes: 2,    exp_last: 1};
        vecs[1] = '{cnt: 1,    mode: 1, exp_writes: 1,    exp_last: 0};
        vecs[2] = '{cnt: 3,    mode: 2, exp_writes: 3,    exp_last: 2};
        vecs[3] = '{cnt: 0,    mode: 0, exp_writes: 0,    exp_last: 0};
        vecs[4] = '{cnt: 7,    mode: 2, exp_writes: 7,    exp_last: 6};
        vecs[5] = '{cnt: 2000, mode: 0, exp_writes: 1024, exp_last: 1023};

        fixed_bytes[0] = 8'h78; fixed_bytes[1] = 8'h56; fixed_bytes[2] = 8'h34; fixed_bytes[3] = 8'h12;
        fixed_bytes[4] = 8'hEF; fixed_bytes[5] = 8'hBE; fixed_bytes[6] = 8'hAD; fixed_bytes[7] = 8'hDE;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rstb = 1'b1;

        // Idle: in_valid must not be acknowledged, core stays in reset.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        chk("idle in_ready", in_ready, 0);
        chk("idle core_rst", core_rst, 1);
        chk("idle busy", busy, 0);
        in_valid = 1'b0;

        // Fixed two-word load.
        byteq.delete();
        for (int i = 0; i < 8; i++) byteq.push_back(fixed_bytes[i]);
        run_load(2, 0, 2, 1, "fixed");
        if (wq_data.size() == 2) begin
            chk("fixed word0", wq_data[0], 32'h12345678);
            chk("fixed word1", wq_data[1], 32'hDEADBEEF);
        end

`ifdef MEM_LOADER_DUMP_EN
        begin
            logic [7:0] rx [$];
            int stall;
            int cyc;
            nbefore = wq_addr.size();
            start_op(1'b0, 0, 1'b1, 2);
            chk("dump busy", busy, 1);
            stall = 0;
            cyc   = 0;
            while (rx.size() < 8 && cyc < 400) begin
                @(negedge clk);
                cyc++;
                out_ready = 1'b0;
                if (out_valid) begin
                    if (stall == 3) begin
                        rx.push_back(out_data);
                        out_ready = 1'b1;
                        stall = 0;
                    end else begin
                        stall++;
                    end
                end
            end
            @(negedge clk);
            out_ready = 1'b0;
            chk("dump nbytes", rx.size(), 8);
            for (int i = 0; i < rx.size() && i < 8; i++)
                chk($sformatf("dump byte[%0d]", i), rx[i], fixed_bytes[i]);
            wait_done(20);
            chk("dump done", done, 1);
            chk("dump core_rst kept", core_rst, 0);
            chk("dump no writes", wq_addr.size(), nbefore);
        end

        // Simultaneous load and dump: load wins.
        fill_random(1);
        wq_addr.delete();
        wq_data.delete();
        start_op(1'b1, 1, 1'b1, 1);
        chk("collide in_ready", in_ready, 1);
        feed(4, 0, sent);
        wait_done(20);
        chk("collide nwrites", wq_addr.size(), 1);
        chk("collide out_valid", out_valid, 0);
`endif

        for (int v = 0; v < 6; v++) begin
            fill_random((vecs[v].cnt > LENGTH) ? LENGTH : vecs[v].cnt);
            run_load(vecs[v].cnt, vecs[v].mode, vecs[v].exp_writes, vecs[v].exp_last,
                     $sformatf("vec%0d", v));
        end

        // load_start while busy must be ignored.
        fill_random(1);
        wq_addr.delete();
        wq_data.delete();
        start_op(1'b1, 1, 1'b0, 0);
        feed(2, 0, sent);
        chk("busy_ign busy", busy, 1);
        @(negedge clk);
        load_start = 1'b1;
        load_count = (AW+1)'(5);
        @(negedge clk);
        load_start = 1'b0;
        feed(2, 0, sent);
        wait_done(20);
        chk("busy_ign done", done, 1);
        chk("busy_ign nwrites", wq_addr.size(), 1);
        if (wq_data.size() > 0) chk("busy_ign data", wq_data[0], model_word(0));

        // Reset in the middle of the second word.
        fill_random(2);
        wq_addr.delete();
        wq_data.delete();
        start_op(1'b1, 2, 1'b0, 0);
        feed(6, 0, sent);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        chk_reset("midreset");
        chk("midreset nwrites", wq_addr.size(), 1);
        @(negedge clk);
        rstb = 1'b1;
        fill_random(1);
        run_load(1, 0, 1, 0, "postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameters: N 32 data width; LENGTH 1024 memory depth in words; AW $clog2(LENGTH) address width.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rstb  input  1  asynchronous active-low reset.
REQ-004 load_start  input  1  one-cycle pulse, begins a load.
REQ-005 load_count  input  AW+1  words to load, captured on load_start.
REQ-006 in_valid / in_ready / in_data  input / output / input  1/1/8  byte-stream sink, transfer when both high.
REQ-007 wr_ena1 / addr1 / din1  output  1/N/N  memory port-1 write side, word address.
REQ-008 dout1  input  N  memory port-1 read data, valid the cycle after addr1 is driven.
REQ-009 core_rst  output  1  active-high reset to mips_core; holds core while memory is being loaded.
REQ-010 busy / done  output  1/1  operation in progress / sticky completion flag.
REQ-011 dump_start, dump_count, out_valid, out_ready, out_data  in/in/out/in/out  1/AW+1/1/1/8  present only under MEM_LOADER_DUMP_EN.

Function
REQ-012 States: IDLE, LOAD, WRITE, DONE; DUMP_RD, DUMP_WAIT, DUMP_TX added under MEM_LOADER_DUMP_EN.
REQ-013 IDLE/DONE + load_start: capture count (values above LENGTH clamp to LENGTH), word index 0, core_rst=1, done=0, go LOAD; count 0 -> DONE next cycle with no write.
REQ-014 LOAD: in_ready=1; bytes packed little-endian (byte 0 -> din bits 7:0); 4th accepted byte -> WRITE.
REQ-015 WRITE: wr_ena1=1 for exactly one cycle, addr1=word index, din1=packed word; in_ready=0; then index+1; last word -> DONE, else LOAD.
REQ-016 Throughput: one word per 5 cycles minimum (4 byte cycles + 1 write cycle).
REQ-017 DONE: done=1, busy=0, core_rst=0; remains until next load_start or reset.
REQ-018 busy=1 in every state except IDLE and DONE; load_start/dump_start while busy are ignored.
REQ-019 load_start and dump_start in the same cycle: load wins, dump dropped.
REQ-020 in_valid outside LOAD: no byte consumed, in_ready=0.
REQ-021 wr_ena1=0 in every state except WRITE; addr1/din1 hold last value otherwise.

Reset
REQ-022 rstb low, at any time including mid-word: state IDLE, partial word discarded, index 0.
REQ-023 Reset values: core_rst=1, in_ready=0, wr_ena1=0, addr1=0, din1=0, busy=0, done=0, out_valid=0, out_data=0.
REQ-024 core_rst stays 1 after reset until the first load reaches DONE.

Configuration
REQ-025 Macro MEM_LOADER_DUMP_EN defined: dump ports and states built; dump_start in IDLE/DONE captures clamped dump_count, keeps core_rst at its current value, goes DUMP_RD.
REQ-026 Dump: DUMP_RD drives addr1=index; DUMP_WAIT latches dout1; DUMP_TX emits 4 bytes little-endian, out_valid held, byte advances only on out_ready; after last word -> DONE.
REQ-027 Dump never asserts wr_ena1; count 0 -> DONE next cycle.
REQ-028 Macro undefined: dump ports absent, dump states unreachable/absent, load behaviour identical.

Structure
REQ-029 Package mem_loader_pkg: state enumeration, BYTES_PER_WORD=4, byte-lane index typedef.
REQ-030 One sub-module, mem_loader_packer: 4-byte shift/pack register with byte counter, shared by load (pack) and dump (unpack).

Verification
REQ-031 Reset then load_count=2, bytes 78 56 34 12 EF BE AD DE -> writes addr 0 = 0x12345678, addr 1 = 0xDEADBEEF, done=1, core_rst falls.
REQ-032 in_valid toggled every other cycle during load of 1 word -> exactly one wr_ena1 pulse, correct word, no dropped or duplicated byte.
REQ-033 rstb low after 2 bytes of word 1 -> no write, all outputs at reset values; new load starts cleanly at addr 0.
REQ-034 load_count=2000 -> 1024 writes, last addr 1023, no wrap to 0.
REQ-035 load_start with load_count=0 -> no wr_ena1, DONE one cycle later; load_start while busy -> ignored.
REQ-036 MEM_LOADER_DUMP_EN: after REQ-031 load, dump_count=2 with out_ready stalled 3 cycles per byte -> out_data 78 56 34 12 EF BE AD DE, no wr_ena1.
